// File: rtl/multi_zone_light_control.sv
// Per-zone occupancy lighting: each zone turns on when dark and occupied, and turns off when bright or vacant.
// Define LIGHT_HOLD_TIMER_EN to add a HOLD state that keeps the light on for HOLD_CYCLES after presence ends.
module multi_zone_light_control #(
    parameter int unsigned ZONES       = 4,
    parameter int unsigned LUM_W       = 8,
    parameter int unsigned LUM_THRESH  = 16,
    parameter int unsigned LUM_HYST    = 8,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LUM_W-1:0]             lum_sen,
    input  logic [ZONES-1:0]             motion_sen,
    input  logic [ZONES-1:0]             ir_sen,
    input  logic [ZONES-1:0]             manual,
    output logic [ZONES-1:0]             int_light,
    output logic [$clog2(ZONES+1)-1:0]   occ_count
);

    localparam int unsigned OCC_W      = $clog2(ZONES + 1);
    localparam int unsigned LUM_X_W    = LUM_W + 1;
    localparam int unsigned BRIGHT_SUM = LUM_THRESH + LUM_HYST;
    localparam int unsigned LUM_MAX    = (2 ** LUM_W) - 1;
    localparam bit          NEVER_BRIGHT = (BRIGHT_SUM > LUM_MAX);
    localparam logic [LUM_X_W-1:0] THRESH_X = LUM_X_W'(LUM_THRESH);
    localparam logic [LUM_X_W-1:0] BRIGHT_X = LUM_X_W'(BRIGHT_SUM);

`ifdef LIGHT_HOLD_TIMER_EN
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_HOLD = 2'd2
    } zone_state_e;
`else
    typedef enum logic [0:0] {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } zone_state_e;
`endif

    logic [LUM_X_W-1:0] lum_x;
    logic               dark;
    logic               bright;
    logic [ZONES-1:0]   on_d;
    logic [ZONES-1:0]   act_d;
    logic [OCC_W-1:0]   on_cnt;

    logic [ZONES-1:0]   int_light_q;
    logic [OCC_W-1:0]   occ_count_q;

    // Shared light level decode, widened so THRESH+HYST cannot wrap.
    assign lum_x  = {1'b0, lum_sen};
    assign dark   = (lum_x < THRESH_X);
    assign bright = !NEVER_BRIGHT && (lum_x >= BRIGHT_X);

    for (genvar g = 0; g < ZONES; g++) begin : g_zone
        zone_state_e state_q;
        zone_state_e state_d;
        logic        presence;

        assign presence = motion_sen[g] | ir_sen[g];

`ifdef LIGHT_HOLD_TIMER_EN
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_OFF;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Bright wins over presence and the hold timer while lit.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_OFF: begin
                    if (dark && presence) begin
                        state_d = ST_ON;
                    end
                end
                ST_ON: begin
                    if (bright) begin
                        state_d = ST_OFF;
                    end else if (!presence) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (bright) begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                    end else if (presence) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
`else
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_OFF;
            end else begin
                state_q <= state_d;
            end
        end

        // Without a hold timer the zone drops out on the first vacant edge.
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_OFF: begin
                    if (dark && presence) begin
                        state_d = ST_ON;
                    end
                end
                ST_ON: begin
                    if (bright || !presence) begin
                        state_d = ST_OFF;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
`endif

        assign on_d[g]  = (state_d == ST_ON);
        assign act_d[g] = (state_d != ST_OFF);
    end : g_zone

    always_comb begin
        on_cnt = '0;
        for (int i = 0; i < ZONES; i++) begin
            on_cnt = on_cnt + OCC_W'(on_d[i]);
        end
    end

    // Manual override only affects the drive, never the zone state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_light_q <= '0;
            occ_count_q <= '0;
        end else begin
            int_light_q <= act_d | manual;
            occ_count_q <= on_cnt;
        end
    end

    assign int_light = int_light_q;
    assign occ_count = occ_count_q;

endmodule : multi_zone_light_control

// File: tb/tb_multi_zone_light_control.sv
// Bench for multi_zone_light_control: directed scenarios plus random stimulus against an occupancy model.
// The model tracks whether LIGHT_HOLD_TIMER_EN is defined for this build.
module tb_multi_zone_light_control;

    localparam int unsigned ZONES       = 4;
    localparam int unsigned LUM_W       = 8;
    localparam int unsigned LUM_THRESH  = 16;
    localparam int unsigned LUM_HYST    = 8;
    localparam int unsigned HOLD_CYCLES = 4;
`ifdef LIGHT_HOLD_TIMER_EN
    localparam int HOLD_EFF = HOLD_CYCLES;
`else
    localparam int HOLD_EFF = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] lum_sen;
    logic [3:0] motion_sen;
    logic [3:0] ir_sen;
    logic [3:0] manual;
    logic [3:0] int_light;
    logic [2:0] occ_count;

    int errors = 0;
    int checks = 0;

    // Model: a zone is lit after turning on, and 'idle' counts vacant edges since presence was last seen.
    bit         act  [ZONES];
    int         idle [ZONES];
    logic [3:0] exp_light;
    logic [2:0] exp_occ;

    multi_zone_light_control #(
        .ZONES      (ZONES),
        .LUM_W      (LUM_W),
        .LUM_THRESH (LUM_THRESH),
        .LUM_HYST   (LUM_HYST),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .lum_sen   (lum_sen),
        .motion_sen(motion_sen),
        .ir_sen    (ir_sen),
        .manual    (manual),
        .int_light (int_light),
        .occ_count (occ_count)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < ZONES; i++) begin
            act[i]  = 1'b0;
            idle[i] = 0;
        end
        exp_light = 4'b0000;
        exp_occ   = 3'd0;
    endtask

    task automatic model_edge();
        bit p;
        bit d;
        bit b;
        int on_n;
        on_n = 0;
        d = (int'(lum_sen) < int'(LUM_THRESH));
        b = (int'(lum_sen) >= int'(LUM_THRESH + LUM_HYST));
        for (int i = 0; i < ZONES; i++) begin
            p = motion_sen[i] | ir_sen[i];
            if (!act[i]) begin
                if (d && p) begin
                    act[i]  = 1'b1;
                    idle[i] = 0;
                end
            end else if (b) begin
                act[i] = 1'b0;
            end else if (p) begin
                idle[i] = 0;
            end else begin
                idle[i]++;
                if (idle[i] > HOLD_EFF) act[i] = 1'b0;
            end
            exp_light[i] = act[i] | manual[i];
            if (act[i] && idle[i] == 0) on_n++;
        end
        exp_occ = 3'(on_n);
    endtask

    task automatic check(input string tag, input logic [3:0] l, input logic [2:0] o);
        checks++;
        assert (int_light === l) else begin
            errors++;
            $error("FAIL %s int_light got %b want %b", tag, int_light, l);
        end
        checks++;
        assert (occ_count === o) else begin
            errors++;
            $error("FAIL %s occ_count got %0d want %0d", tag, occ_count, o);
        end
    endtask

    task automatic step(input logic [7:0] l, input logic [3:0] ms, input logic [3:0] ir,
                        input logic [3:0] man, input string tag);
        @(negedge clk);
        lum_sen    = l;
        motion_sen = ms;
        ir_sen     = ir;
        manual     = man;
        @(posedge clk);
        model_edge();
        #1;
        check(tag, exp_light, exp_occ);
    endtask

    task automatic async_reset_pulse(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check(tag, 4'b0000, 3'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int lit;
        logic [7:0] rl;
        logic [3:0] rm;
        logic [3:0] ri;
        logic [3:0] rman;

        reset      = 1'b0;
        lum_sen    = 8'd0;
        motion_sen = 4'b0000;
        ir_sen     = 4'b0000;
        manual     = 4'b0000;
        model_clear();
        #3;
        check("reset_state", 4'b0000, 3'd0);
        @(negedge clk);
        reset = 1'b1;

        // Bright and idle: everything stays dark.
        for (int k = 0; k < 10; k++) step(8'd128, 4'b0000, 4'b0000, 4'b0000, "idle_bright");

        // Single motion pulse on zone 0 followed by the hold period.
        step(8'd8, 4'b0001, 4'b0000, 4'b0000, "z0_on");
        checks++;
        assert (int_light === 4'b0001 && occ_count === 3'd1) else begin
            errors++;
            $error("FAIL z0_on_const got %b/%0d want 0001/1", int_light, occ_count);
        end
        lit = 1;
        for (int k = 0; k < 8; k++) begin
            step(8'd8, 4'b0000, 4'b0000, 4'b0000, "z0_hold");
            if (int_light[0]) lit++;
        end
        checks++;
        assert (lit == 1 + HOLD_EFF) else begin
            errors++;
            $error("FAIL z0_lit_cycles got %0d want %0d", lit, 1 + HOLD_EFF);
        end

        // Zone 1: IR re-trigger late in the hold period restarts the timer.
        step(8'd8, 4'b0000, 4'b0010, 4'b0000, "z1_on");
        for (int k = 0; k < 3; k++) step(8'd8, 4'b0000, 4'b0000, 4'b0000, "z1_hold");
        step(8'd8, 4'b0000, 4'b0010, 4'b0000, "z1_retrig");
        checks++;
        assert (int_light[1] === 1'b1 && occ_count === 3'd1) else begin
            errors++;
            $error("FAIL z1_retrig_const got %b/%0d want x1x/1", int_light, occ_count);
        end
        lit = 0;
        for (int k = 0; k < 8; k++) begin
            step(8'd8, 4'b0000, 4'b0000, 4'b0000, "z1_hold2");
            if (int_light[1]) lit++;
        end
        checks++;
        assert (lit == HOLD_EFF) else begin
            errors++;
            $error("FAIL z1_hold_after_retrig got %0d want %0d", lit, HOLD_EFF);
        end

        // Zone 2: hysteresis band keeps it on, bright level forces it off.
        step(8'd8,  4'b0100, 4'b0000, 4'b0000, "z2_on");
        step(8'd20, 4'b0100, 4'b0000, 4'b0000, "z2_band");
        checks++;
        assert (int_light[2] === 1'b1) else begin
            errors++;
            $error("FAIL z2_band_const got %b want 1", int_light[2]);
        end
        step(8'd23, 4'b0100, 4'b0000, 4'b0000, "z2_band_top");
        step(8'd24, 4'b0100, 4'b0000, 4'b0000, "z2_bright");
        checks++;
        assert (int_light[2] === 1'b0) else begin
            errors++;
            $error("FAIL z2_bright_const got %b want 0", int_light[2]);
        end
        step(8'd20, 4'b0100, 4'b0000, 4'b0000, "z2_band_off");
        step(8'd16, 4'b0100, 4'b0000, 4'b0000, "z2_at_thresh");
        step(8'd15, 4'b0100, 4'b0000, 4'b0000, "z2_below_thresh");
        step(8'd255, 4'b0000, 4'b0000, 4'b0000, "z2_max_lum");

        // Manual force-on does not touch occupancy.
        step(8'd128, 4'b0000, 4'b0000, 4'b1000, "manual_on");
        checks++;
        assert (int_light === 4'b1000 && occ_count === 3'd0) else begin
            errors++;
            $error("FAIL manual_const got %b/%0d want 1000/0", int_light, occ_count);
        end
        step(8'd128, 4'b0000, 4'b0000, 4'b1000, "manual_hold");
        step(8'd128, 4'b0000, 4'b0000, 4'b0000, "manual_off");

        // All zones on, then asynchronous reset between edges.
        step(8'd8, 4'b1111, 4'b0000, 4'b0000, "all_on");
        checks++;
        assert (occ_count === 3'd4) else begin
            errors++;
            $error("FAIL all_on_count got %0d want 4", occ_count);
        end
        async_reset_pulse("async_reset_on");
        step(8'd8, 4'b0000, 4'b0000, 4'b0000, "after_reset_on");

        // Reset in the middle of a hold drops the remaining hold time.
        step(8'd8, 4'b0000, 4'b1111, 4'b0000, "all_on2");
        step(8'd8, 4'b0000, 4'b0000, 4'b0000, "all_hold");
        async_reset_pulse("async_reset_hold");
        step(8'd8, 4'b0000, 4'b0000, 4'b0000, "after_reset_hold");

        // Random traffic concentrated around the threshold band.
        for (int k = 0; k < 400; k++) begin
            rl   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(10, 28));
            rm   = 4'($urandom) & 4'($urandom);
            ri   = 4'($urandom) & 4'($urandom) & 4'($urandom);
            rman = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            step(rl, rm, ri, rman, "random");
            if (k % 97 == 96) async_reset_pulse("random_reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multi_zone_light_control
